// File: rtl/psum_out_fifo_pkg.sv
// Shared constants for the MAC array output path and a pointer-width helper.
package psum_out_fifo_pkg;

    localparam int unsigned COL     = 8;
    localparam int unsigned PSUM_BW = 16;

    // Bits needed to index 'value' entries (ceil(log2(value))).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned bits;
        bits = 0;
        for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/psum_out_fifo_col_fifo.sv
// Single-column circular FIFO: storage, write pointer and occupancy count.
// The read pointer is shared across columns and supplied by the parent.
module col_fifo
    import psum_out_fifo_pkg::*;
#(
    parameter int unsigned psum_bw = PSUM_BW,
    parameter int unsigned depth   = 16,
    localparam int unsigned ptr_w  = clog2(depth),
    localparam int unsigned cnt_w  = ptr_w + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [psum_bw-1:0] din,
    input  logic               wr,
    input  logic               pop,
    input  logic [ptr_w-1:0]   rd_ptr,
    output logic [psum_bw-1:0] head_c,
    output logic               nonempty_c,
    output logic               full_c,
    output logic               drop_c
);

    logic [psum_bw-1:0] mem [depth];
    logic [ptr_w-1:0]   wr_ptr;
    logic [cnt_w-1:0]   count;
    logic               wr_acc;

    assign full_c     = (count == cnt_w'(depth));
    assign nonempty_c = (count != '0);
    // A full column still takes a write when the same edge pops a row.
    assign wr_acc     = wr && (!full_c || pop);
    assign drop_c     = wr && !wr_acc;
    assign head_c     = mem[rd_ptr];

    // Pointer and occupancy tracking; a concurrent write and pop cancel out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ptr_w'(1);
            end
            case ({wr_acc, pop})
                2'b10:   count <= count + cnt_w'(1);
                2'b01:   count <= count - cnt_w'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone defines valid entries.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/psum_out_fifo.sv
// Per-column partial-sum FIFOs that realign skewed array outputs into rows.
// Columns fill independently; pops are row-aligned via one shared read pointer.
module psum_out_fifo
    import psum_out_fifo_pkg::*;
#(
    parameter int unsigned col     = COL,
    parameter int unsigned psum_bw = PSUM_BW,
    parameter int unsigned depth   = 16,
    localparam int unsigned ptr_w  = clog2(depth),
    localparam int unsigned row_w  = psum_bw * col
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [row_w-1:0] in,
    input  logic [col-1:0]   wr,
    input  logic             rd,
    output logic [row_w-1:0] out,
    output logic             o_valid,
    output logic             o_full,
    output logic             overflow
);

    logic [ptr_w-1:0] rd_ptr;
    logic [row_w-1:0] head_row;
    logic [col-1:0]   nonempty;
    logic [col-1:0]   full;
    logic [col-1:0]   drop;
    logic             pop_c;

    for (genvar c = 0; c < col; c++) begin : g_col
        col_fifo #(
            .psum_bw (psum_bw),
            .depth   (depth)
        ) u_fifo (
            .clk        (clk),
            .reset      (reset),
            .din        (in[psum_bw*c +: psum_bw]),
            .wr         (wr[c]),
            .pop        (pop_c),
            .rd_ptr     (rd_ptr),
            .head_c     (head_row[psum_bw*c +: psum_bw]),
            .nonempty_c (nonempty[c]),
            .full_c     (full[c]),
            .drop_c     (drop[c])
        );
    end

    // Flags come straight from counts registered at the previous edge.
    assign o_valid = &nonempty;
    assign o_full  = |full;
    assign pop_c   = rd && o_valid;

    // Shared read pointer, popped-row register and sticky drop flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr   <= '0;
            out      <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop_c) begin
                rd_ptr <= rd_ptr + ptr_w'(1);
                out    <= head_row;
            end
            if (|drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_psum_out_fifo.sv
// Self-checking bench for psum_out_fifo against a queue-based row model.
module tb_psum_out_fifo;

    localparam int unsigned COLS  = 8;
    localparam int unsigned BW    = 16;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned RW    = COLS * BW;

    logic          clk = 1'b0;
    logic          reset;
    logic [RW-1:0] in_d;
    logic [COLS-1:0] wr;
    logic          rd;
    logic [RW-1:0] out;
    logic          o_valid;
    logic          o_full;
    logic          overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: one queue per column, the last popped row, sticky drop flag.
    logic [BW-1:0] mq [COLS][$];
    logic [RW-1:0] m_out;
    logic          m_ovf;

    always #5 clk = ~clk;

    psum_out_fifo #(
        .col     (COLS),
        .psum_bw (BW),
        .depth   (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in_d),
        .wr       (wr),
        .rd       (rd),
        .out      (out),
        .o_valid  (o_valid),
        .o_full   (o_full),
        .overflow (overflow)
    );

    function automatic logic m_valid();
        for (int c = 0; c < COLS; c++) if (mq[c].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic m_full();
        for (int c = 0; c < COLS; c++) if (mq[c].size() == DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < COLS; c++) mq[c].delete();
        m_out = '0;
        m_ovf = 1'b0;
    endfunction

    function automatic logic [RW-1:0] row_of(input logic [BW-1:0] v);
        logic [RW-1:0] r;
        for (int c = 0; c < COLS; c++) r[BW*c +: BW] = v;
        return r;
    endfunction

    // Apply one cycle of stimulus, advance the model, return 1 time unit past the edge.
    task automatic step(input logic [COLS-1:0] w, input logic [RW-1:0] d, input logic r);
        logic pop;
        int   sz [COLS];
        wr = w; in_d = d; rd = r;
        pop = r && m_valid();
        for (int c = 0; c < COLS; c++) sz[c] = mq[c].size();
        @(posedge clk);
        if (pop) for (int c = 0; c < COLS; c++) m_out[BW*c +: BW] = mq[c].pop_front();
        for (int c = 0; c < COLS; c++) begin
            if (w[c]) begin
                if (sz[c] < DEPTH || pop) mq[c].push_back(d[BW*c +: BW]);
                else m_ovf = 1'b1;
            end
        end
        #1;
        wr = '0; rd = 1'b0; in_d = '0;
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (out !== '0) begin n_fail++; $display("FAIL reset_out: got %h want 0", out); end
        n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        n_cmp++; if (o_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", o_full); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release_valid: got %b want 0", o_valid); end
    endtask

    task automatic test_skewed_fill();
        logic [RW-1:0] d;
        do_reset();
        for (int c = 0; c < COLS; c++) begin
            n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL skew_valid_early c=%0d: got %b want 0", c, o_valid); end
            d = '0;
            d[BW*c +: BW] = 16'h0100 + BW'(c);
            step(COLS'(1) << c, d, 1'b0);
        end
        n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL skew_valid_rise: got %b want 1", o_valid); end
        step('0, '0, 1'b1);
        n_cmp++; if (out !== 128'h0107_0106_0105_0104_0103_0102_0101_0100) begin n_fail++; $display("FAIL skew_out: got %h want 0107..0100", out); end
        n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL skew_valid_after_pop: got %b want 0", o_valid); end
    endtask

    task automatic test_full_boundary();
        do_reset();
        for (int i = 0; i < DEPTH; i++) step('1, row_of(16'h1000 + BW'(i)), 1'b0);
        n_cmp++; if (o_full !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %b want 1", o_full); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_no_ovf: got %b want 0", overflow); end
        step('1, row_of(16'hDEAD), 1'b0);
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL full_ovf_set: got %b want 1", overflow); end
        for (int i = 0; i < DEPTH; i++) begin
            step('0, '0, 1'b1);
            n_cmp++; if (out !== row_of(16'h1000 + BW'(i))) begin n_fail++; $display("FAIL full_pop_%0d: got %h want %h", i, out, row_of(16'h1000 + BW'(i))); end
        end
        n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL full_drained_valid: got %b want 0", o_valid); end
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL full_ovf_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_write_full_pop();
        do_reset();
        for (int i = 0; i < DEPTH; i++) step('1, row_of(16'h2000 + BW'(i)), 1'b0);
        step('1, row_of(16'h20AA), 1'b1);
        n_cmp++; if (out !== row_of(16'h2000)) begin n_fail++; $display("FAIL wfp_first: got %h want %h", out, row_of(16'h2000)); end
        n_cmp++; if (o_full !== 1'b1) begin n_fail++; $display("FAIL wfp_still_full: got %b want 1", o_full); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL wfp_no_ovf: got %b want 0", overflow); end
        for (int i = 1; i <= DEPTH; i++) begin
            step('0, '0, 1'b1);
            n_cmp++;
            if (out !== ((i == DEPTH) ? row_of(16'h20AA) : row_of(16'h2000 + BW'(i)))) begin
                n_fail++; $display("FAIL wfp_pop_%0d: got %h", i, out);
            end
        end
        n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL wfp_drained: got %b want 0", o_valid); end
    endtask

    task automatic test_empty_read();
        logic [RW-1:0] exp;
        do_reset();
        step('1, row_of(16'h3000), 1'b0);
        step('0, '0, 1'b1);
        step(8'hF7, row_of(16'h3111), 1'b0);
        step(8'hF7, row_of(16'h3222), 1'b0);
        n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL empty_valid: got %b want 0", o_valid); end
        step('0, '0, 1'b1);
        step('0, '0, 1'b1);
        n_cmp++; if (out !== row_of(16'h3000)) begin n_fail++; $display("FAIL empty_out_hold: got %h want %h", out, row_of(16'h3000)); end
        step(8'h08, row_of(16'h3333), 1'b0);
        n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL empty_valid_after_fill: got %b want 1", o_valid); end
        step('0, '0, 1'b1);
        exp = row_of(16'h3111);
        exp[BW*3 +: BW] = 16'h3333;
        n_cmp++; if (out !== exp) begin n_fail++; $display("FAIL empty_head_kept: got %h want %h", out, exp); end
        n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL empty_col3_drained: got %b want 0", o_valid); end
    endtask

    task automatic test_wrap();
        do_reset();
        step('1, row_of(16'd0), 1'b0);
        for (int i = 1; i < 40; i++) begin
            step('1, row_of(BW'(i)), 1'b1);
            n_cmp++; if (out !== row_of(BW'(i - 1))) begin n_fail++; $display("FAIL wrap_%0d: got %h want %h", i - 1, out, row_of(BW'(i - 1))); end
        end
        step('0, '0, 1'b1);
        n_cmp++; if (out !== row_of(16'd39)) begin n_fail++; $display("FAIL wrap_39: got %h want %h", out, row_of(16'd39)); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf: got %b want 0", overflow); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 5; i++) step('1, row_of(16'h5000 + BW'(i)), 1'b0);
        step('0, '0, 1'b1);
        #2 reset = 1'b1;
        #1;
        model_reset();
        n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b want 0", o_valid); end
        n_cmp++; if (out !== '0) begin n_fail++; $display("FAIL arst_out: got %h want 0", out); end
        @(negedge clk);
        reset = 1'b0;
        step('1, row_of(16'h5AAA), 1'b0);
        n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL arst_first_write: got %b want 1", o_valid); end
        step('0, '0, 1'b1);
        n_cmp++; if (out !== row_of(16'h5AAA)) begin n_fail++; $display("FAIL arst_new_data: got %h want %h", out, row_of(16'h5AAA)); end
        n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL arst_old_discarded: got %b want 0", o_valid); end
    endtask

    task automatic test_random();
        logic [RW-1:0] d;
        int rd_pct;
        for (int seg = 0; seg < 2; seg++) begin
            do_reset();
            rd_pct = (seg == 0) ? 70 : 20;
            for (int n = 0; n < 300; n++) begin
                d = {$urandom, $urandom, $urandom, $urandom};
                step(COLS'($urandom_range(0, 255)), d, ($urandom_range(0, 99) < rd_pct));
                n_cmp++; if (out !== m_out) begin n_fail++; $display("FAIL rand_out s%0d n%0d: got %h want %h", seg, n, out, m_out); end
                n_cmp++; if (o_valid !== m_valid()) begin n_fail++; $display("FAIL rand_valid s%0d n%0d: got %b want %b", seg, n, o_valid, m_valid()); end
                n_cmp++; if (o_full !== m_full()) begin n_fail++; $display("FAIL rand_full s%0d n%0d: got %b want %b", seg, n, o_full, m_full()); end
                n_cmp++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rand_ovf s%0d n%0d: got %b want %b", seg, n, overflow, m_ovf); end
            end
        end
    endtask

    initial begin
        reset = 1'b1; wr = '0; rd = 1'b0; in_d = '0;
        model_reset();
        test_reset();
        test_skewed_fill();
        test_full_boundary();
        test_write_full_pop();
        test_empty_read();
        test_wrap();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
